dual_stream_arbiter: RTL and testbench

DUAL_STREAM_ARBITER -- requirements
Module: dual_stream_arbiter

---
 rtl/dual_stream_arbiter.sv | 128 ++++++++++++
 tb/tb_dual_stream_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_stream_arbiter.sv
// Merges two frame-aligned 8-bit pixel streams into one, alternating bursts of
// BURST_LEN pixels per channel and realigning both channels on SOF errors.
module dual_stream_arbiter #(
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned FRAME_PIXELS = 307200
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [1:0]  in_valid_i,
  input  logic [7:0]  in_pixel_i [2],
  input  logic [1:0]  in_sof_i,
  output logic [1:0]  in_ready_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  out_pixel_o,
  output logic        out_chan_o,
  output logic        out_sof_o,
  output logic        frame_done_o,
  output logic [15:0] resync_count_o
);

  localparam int unsigned CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam int unsigned BST_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_MAX = CNT_W'(FRAME_PIXELS);
  localparam logic [BST_W-1:0] BURST_MAX = BST_W'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, ALIGN, GRANT0, GRANT1} state_t;

  state_t           state;
  logic [CNT_W-1:0] pix_cnt [2];
  logic [BST_W-1:0] burst_cnt;

  logic             grant_active;
  logic             gsel;
  logic             out_free;
  logic             head_valid;
  logic             head_sof;
  logic             sof_err;
  logic             accept;
  logic             other_done;
  logic             frame_end;
  logic             burst_end;
  logic [CNT_W-1:0] gcnt;
  logic [CNT_W-1:0] gcnt_inc;
  logic [BST_W-1:0] burst_inc;

  // Handshake decode for the granted channel; a mid-frame SOF is never accepted.
  always_comb begin
    grant_active = (state == GRANT0) || (state == GRANT1);
    gsel         = (state == GRANT1);
    out_free     = !out_valid_o || out_ready_i;
    head_valid   = in_valid_i[gsel];
    head_sof     = in_sof_i[gsel];
    gcnt         = pix_cnt[gsel];
    gcnt_inc     = gcnt + CNT_W'(1);
    burst_inc    = burst_cnt + BST_W'(1);
    sof_err      = grant_active && head_valid && head_sof && (gcnt != '0);
    accept       = grant_active && head_valid && out_free && !sof_err;
    other_done   = (pix_cnt[~gsel] == FRAME_MAX);
    frame_end    = (gcnt_inc == FRAME_MAX);
    burst_end    = (burst_inc == BURST_MAX);
    in_ready_o   = '0;
    case (state)
      ALIGN:          in_ready_o = in_valid_i & ~in_sof_i;
      GRANT0, GRANT1: in_ready_o[gsel] = out_free && !sof_err;
      default:        in_ready_o = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      pix_cnt[0]     <= '0;
      pix_cnt[1]     <= '0;
      burst_cnt      <= '0;
      out_valid_o    <= 1'b0;
      out_pixel_o    <= '0;
      out_chan_o     <= 1'b0;
      out_sof_o      <= 1'b0;
      frame_done_o   <= 1'b0;
      resync_count_o <= '0;
    end else begin
      frame_done_o <= 1'b0;
      // Output register drains independently of the arbitration state.
      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
      if (accept) begin
        out_valid_o   <= 1'b1;
        out_pixel_o   <= in_pixel_i[gsel];
        out_chan_o    <= gsel;
        out_sof_o     <= head_sof && (gcnt == '0);
        pix_cnt[gsel] <= gcnt_inc;
      end
      case (state)
        IDLE: if (enable_i) state <= ALIGN;
        ALIGN: begin
          if ((&in_valid_i) && (&in_sof_i)) begin
            state      <= GRANT0;
            pix_cnt[0] <= '0;
            pix_cnt[1] <= '0;
            burst_cnt  <= '0;
          end
        end
        default: begin
          if (sof_err) begin
            if (resync_count_o != 16'hFFFF) resync_count_o <= resync_count_o + 16'd1;
            state <= ALIGN;
          end else if (accept) begin
            // A finished channel is never granted again within the frame.
            if (frame_end && other_done) begin
              frame_done_o <= 1'b1;
              burst_cnt    <= '0;
              state        <= enable_i ? ALIGN : IDLE;
            end else if (frame_end || (burst_end && !other_done)) begin
              burst_cnt <= '0;
              state     <= gsel ? GRANT0 : GRANT1;
            end else if (burst_end) begin
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_inc;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_stream_arbiter.sv
// Directed bench for dual_stream_arbiter: burst ordering, SOF alignment, stall,
// resync and reset, on a BURST_LEN=4 instance with 8- and 6-pixel frames.
module tb_dual_stream_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_en, a_out_ready, a_out_valid, a_out_chan, a_out_sof, a_fd;
  logic [1:0]  a_valid, a_sof, a_ready;
  logic [7:0]  a_pix [2];
  logic [7:0]  a_out_pixel;
  logic [15:0] a_resync;
  logic        b_en, b_out_ready, b_out_valid, b_out_chan, b_out_sof, b_fd;
  logic [1:0]  b_valid, b_sof, b_ready;
  logic [7:0]  b_pix [2];
  logic [7:0]  b_out_pixel;
  logic [15:0] b_resync;

  dual_stream_arbiter #(.BURST_LEN(4), .FRAME_PIXELS(8)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(a_en), .in_valid_i(a_valid),
    .in_pixel_i(a_pix), .in_sof_i(a_sof), .in_ready_o(a_ready),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_pixel_o(a_out_pixel),
    .out_chan_o(a_out_chan), .out_sof_o(a_out_sof), .frame_done_o(a_fd),
    .resync_count_o(a_resync)
  );

  dual_stream_arbiter #(.BURST_LEN(4), .FRAME_PIXELS(6)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(b_en), .in_valid_i(b_valid),
    .in_pixel_i(b_pix), .in_sof_i(b_sof), .in_ready_o(b_ready),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_pixel_o(b_out_pixel),
    .out_chan_o(b_out_chan), .out_sof_o(b_out_sof), .frame_done_o(b_fd),
    .resync_count_o(b_resync)
  );

  // Source queues hold {sof, pixel}; captures hold {chan, sof, pixel}.
  logic [8:0] qa0[$], qa1[$], qb0[$], qb1[$];
  logic [9:0] cap_a[$], cap_b[$];
  int vectors = 0;
  int miscompares = 0;
  int fd_a = 0;
  int fd_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive();
    a_valid  = {qa1.size() > 0, qa0.size() > 0};
    a_pix[0] = (qa0.size() > 0) ? qa0[0][7:0] : 8'h00;
    a_sof[0] = (qa0.size() > 0) ? qa0[0][8]   : 1'b0;
    a_pix[1] = (qa1.size() > 0) ? qa1[0][7:0] : 8'h00;
    a_sof[1] = (qa1.size() > 0) ? qa1[0][8]   : 1'b0;
    b_valid  = {qb1.size() > 0, qb0.size() > 0};
    b_pix[0] = (qb0.size() > 0) ? qb0[0][7:0] : 8'h00;
    b_sof[0] = (qb0.size() > 0) ? qb0[0][8]   : 1'b0;
    b_pix[1] = (qb1.size() > 0) ? qb1[0][7:0] : 8'h00;
    b_sof[1] = (qb1.size() > 0) ? qb1[0][8]   : 1'b0;
  endtask

  task automatic push_frame(input int q, input logic [7:0] base, input int n);
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      e = {(i == 0), 8'(base + 8'(i))};
      case (q)
        0: qa0.push_back(e);
        1: qa1.push_back(e);
        2: qb0.push_back(e);
        default: qb1.push_back(e);
      endcase
    end
  endtask

  // One clock: sample handshakes mid-cycle, then advance sources after the edge.
  task automatic tick();
    logic [1:0] acc_a, acc_b;
    @(negedge clk);
    acc_a = a_valid & a_ready;
    acc_b = b_valid & b_ready;
    if (a_out_valid && a_out_ready) cap_a.push_back({a_out_chan, a_out_sof, a_out_pixel});
    if (b_out_valid && b_out_ready) cap_b.push_back({b_out_chan, b_out_sof, b_out_pixel});
    if (a_fd) fd_a++;
    if (b_fd) fd_b++;
    @(posedge clk);
    #1;
    if (acc_a[0]) void'(qa0.pop_front());
    if (acc_a[1]) void'(qa1.pop_front());
    if (acc_b[0]) void'(qb0.pop_front());
    if (acc_b[1]) void'(qb1.pop_front());
    drive();
  endtask

  task automatic run_until(input bit use_b, input int n, input string tag);
    int budget = 0;
    while (((use_b ? cap_b.size() : cap_a.size()) < n) && budget < 400) begin
      tick();
      budget++;
    end
    chk({tag, "_count"}, 32'(use_b ? cap_b.size() : cap_a.size()), 32'(n));
  endtask

  // Expected pixel is base plus how many pixels that channel has sent so far.
  task automatic check_seq(input string tag, input bit use_b, input int start, input int n,
                           input logic [31:0] chans, input logic [7:0] base0,
                           input logic [7:0] base1);
    int k0, k1, sz;
    logic c;
    logic [9:0] exp_e, obs;
    k0 = 0;
    k1 = 0;
    sz = use_b ? cap_b.size() : cap_a.size();
    for (int i = 0; i < n; i++) begin
      c = chans[n-1-i];
      if (!c) begin
        exp_e = {1'b0, (k0 == 0), 8'(base0 + 8'(k0))};
        k0++;
      end else begin
        exp_e = {1'b1, (k1 == 0), 8'(base1 + 8'(k1))};
        k1++;
      end
      obs = 'x;
      if (start + i < sz) obs = use_b ? cap_b[start+i] : cap_a[start+i];
      chk($sformatf("%s_out%0d", tag, i), 32'(obs), 32'(exp_e));
    end
  endtask

  initial begin
    rst = 1'b1;
    a_en = 1'b0;
    b_en = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    drive();
    #12;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready", 32'(a_ready), 32'd0);
    chk("rst_resync", 32'(a_resync), 32'd0);
    chk("rst_out_pixel", 32'(a_out_pixel), 32'd0);
    chk("rst_frame_done", 32'(a_fd), 32'd0);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Burst ordering with three leading non-SOF pixels on channel 1.
    push_frame(0, 8'h00, 8);
    qa1.push_back({1'b0, 8'hF0});
    qa1.push_back({1'b0, 8'hF1});
    qa1.push_back({1'b0, 8'hF2});
    push_frame(1, 8'h80, 8);
    a_en = 1'b1;
    drive();
    run_until(1'b0, 16, "t1");
    repeat (3) tick();
    check_seq("t1", 1'b0, 0, 16, 32'b0000_1111_0000_1111, 8'h00, 8'h80);
    chk("t1_frame_done", 32'(fd_a), 32'd1);
    chk("t1_junk_gone", 32'(qa1.size()), 32'd0);
    chk("t1_resync", 32'(a_resync), 32'd0);

    // Downstream stall holds the output and blocks both inputs.
    cap_a.delete();
    fd_a = 0;
    push_frame(0, 8'h10, 8);
    push_frame(1, 8'h90, 8);
    drive();
    for (int w = 0; w < 50 && !a_out_valid; w++) tick();
    chk("t2_first_valid", 32'(a_out_valid), 32'd1);
    a_out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("t2_stall_valid", 32'(a_out_valid), 32'd1);
      chk("t2_stall_data", 32'({a_out_chan, a_out_sof, a_out_pixel}), 32'h110);
      chk("t2_stall_ready", 32'(a_ready), 32'd0);
    end
    a_out_ready = 1'b1;
    run_until(1'b0, 16, "t2");
    repeat (3) tick();
    check_seq("t2", 1'b0, 0, 16, 32'b0000_1111_0000_1111, 8'h10, 8'h90);
    chk("t2_frame_done", 32'(fd_a), 32'd1);

    // Channel 0 restarts its frame at pixel 3.
    cap_a.delete();
    fd_a = 0;
    qa0.push_back({1'b1, 8'h20});
    qa0.push_back({1'b0, 8'h21});
    qa0.push_back({1'b0, 8'h22});
    push_frame(0, 8'h30, 8);
    push_frame(1, 8'hA0, 8);
    drive();
    run_until(1'b0, 19, "t3");
    repeat (3) tick();
    chk("t3_pre0", 32'(cap_a.size() > 0 ? cap_a[0] : 10'h3FF), 32'h120);
    chk("t3_pre1", 32'(cap_a.size() > 1 ? cap_a[1] : 10'h3FF), 32'h021);
    chk("t3_pre2", 32'(cap_a.size() > 2 ? cap_a[2] : 10'h3FF), 32'h022);
    check_seq("t3", 1'b0, 3, 16, 32'b0000_1111_0000_1111, 8'h30, 8'hA0);
    chk("t3_resync", 32'(a_resync), 32'd1);
    chk("t3_frame_done", 32'(fd_a), 32'd1);

    // Asynchronous reset mid-burst discards the pending pixel.
    cap_a.delete();
    push_frame(0, 8'h50, 8);
    push_frame(1, 8'hD0, 8);
    drive();
    for (int w = 0; w < 50 && cap_a.size() < 2; w++) tick();
    chk("t4_pre_valid", 32'(a_out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t4_rst_valid", 32'(a_out_valid), 32'd0);
    chk("t4_rst_resync", 32'(a_resync), 32'd0);
    chk("t4_rst_ready", 32'(a_ready), 32'd0);
    chk("t4_rst_pixel", 32'(a_out_pixel), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_en = 1'b0;
    qa0.delete();
    qa1.delete();
    drive();
    tick();
    chk("t4_idle_valid", 32'(a_out_valid), 32'd0);

    // Frame end cuts the second burst short on the 6-pixel instance.
    b_en = 1'b1;
    push_frame(2, 8'h40, 6);
    push_frame(3, 8'hC0, 6);
    drive();
    run_until(1'b1, 12, "t5");
    repeat (3) tick();
    check_seq("t5", 1'b1, 0, 12, 32'b0000_1111_0011, 8'h40, 8'hC0);
    chk("t5_frame_done", 32'(fd_b), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
